// File: rtl/game_pkg.sv
// Shared game-side types and constants for the rope contact detector.
// Holds the detector FSM states and VGA coordinate sizing.
package game_pkg;

   localparam int COORD_W  = 11;
   // minX restarts at the far right edge so the first overlap pixel always wins
   localparam int SCREEN_W = 2048;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACCUM      = 2'd1,
      REPORT     = 2'd2
   } state_t;

endpackage

// File: rtl/rope_contact_detector_if.sv
// Raster pixel stream into the rope contact detector and its per-frame results.
// The stream has no backpressure: every clock carries one pixel, and startOfFrame
// flags the first pixel of a frame. On the result side frameDone acts as a
// one-cycle valid for overlapCount/ropeSnapX, and there is no ready signal.
interface rope_contact_detector_if
   import game_pkg::*;
#(
   parameter int CNT_WIDTH = 12
);

   logic                 startOfFrame;
   logic [COORD_W-1:0]   pixelX;
   logic [COORD_W-1:0]   pixelY;
   logic                 ropeDR;
   logic                 playerDR;

   logic                 onRope;
   logic                 grabPulse;
   logic                 releasePulse;
   logic                 frameDone;
   logic [CNT_WIDTH-1:0] overlapCount;
   logic [COORD_W-1:0]   ropeSnapX;

   modport master (
      output startOfFrame, pixelX, pixelY, ropeDR, playerDR,
      input  onRope, grabPulse, releasePulse, frameDone, overlapCount, ropeSnapX
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, ropeDR, playerDR,
      output onRope, grabPulse, releasePulse, frameDone, overlapCount, ropeSnapX
   );

endinterface

// File: rtl/frame_debouncer.sv
// Per-frame debounce of the contact decision: onRope needs a run of contact
// frames to rise and a run of miss frames to fall, with edge pulses.
module frame_debouncer #(
   parameter int GRAB_FRAMES    = 2,
   parameter int RELEASE_FRAMES = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic frameStrobe,
   input  logic frameContact,
   output logic onRope,
   output logic grabPulse,
   output logic releasePulse
);

   localparam int GW = $clog2(GRAB_FRAMES + 1);
   localparam int RW = $clog2(RELEASE_FRAMES + 1);
   localparam logic [GW-1:0] GRAB_MAX    = GW'(GRAB_FRAMES);
   localparam logic [RW-1:0] RELEASE_MAX = RW'(RELEASE_FRAMES);

   logic [GW-1:0] contactStreak, contactNext;
   logic [RW-1:0] missStreak, missNext;

   // Streaks stop at their thresholds, which is all the decision logic needs
   always_comb begin
      contactNext = contactStreak;
      missNext    = missStreak;
      if (frameStrobe) begin
         if (frameContact) begin
            contactNext = (contactStreak == GRAB_MAX) ? GRAB_MAX : contactStreak + 1'b1;
            missNext    = '0;
         end else begin
            missNext    = (missStreak == RELEASE_MAX) ? RELEASE_MAX : missStreak + 1'b1;
            contactNext = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         contactStreak <= '0;
         missStreak    <= '0;
         onRope        <= 1'b0;
         grabPulse     <= 1'b0;
         releasePulse  <= 1'b0;
      end else begin
         contactStreak <= contactNext;
         missStreak    <= missNext;
         grabPulse     <= 1'b0;
         releasePulse  <= 1'b0;
         if (frameStrobe && !onRope && contactNext == GRAB_MAX) begin
            onRope    <= 1'b1;
            grabPulse <= 1'b1;
         end else if (frameStrobe && onRope && missNext == RELEASE_MAX) begin
            onRope       <= 1'b0;
            releasePulse <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rope_contact_detector.sv
// Accumulates rope/player sprite overlap over each VGA frame and publishes
// frame-stable contact results plus a debounced onRope flag.
module rope_contact_detector
   import game_pkg::*;
#(
   parameter int MIN_OVERLAP_PIXELS = 16,
   parameter int GRAB_FRAMES        = 2,
   parameter int RELEASE_FRAMES     = 3,
   parameter int CNT_WIDTH          = 12
) (
   input  logic                    clk,
   input  logic                    resetN,
   rope_contact_detector_if.slave  bus,
   output state_t                  stateDbg
);

   state_t state, nextState;

   logic                 overlap;
   logic                 closeFrame;
   logic [COORD_W-1:0]   x;
   logic [CNT_WIDTH-1:0] cnt;
   logic [COORD_W-1:0]   minX, maxX;
   logic [COORD_W:0]     snapSum;
   logic                 frameDoneR;
   logic [CNT_WIDTH-1:0] overlapCountR;
   logic [COORD_W-1:0]   ropeSnapXR;
   logic                 frameContact;
   logic                 unusedPixelY;

   assign overlap    = bus.ropeDR & bus.playerDR;
   assign x          = bus.pixelX;
   assign closeFrame = bus.startOfFrame && (state != WAIT_FRAME);
   assign snapSum    = {1'b0, minX} + {1'b0, maxX};
   assign unusedPixelY = ^bus.pixelY;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= WAIT_FRAME;
      else         state <= nextState;
   end

   // Back-to-back startOfFrame pulses keep the FSM in REPORT, closing one frame per pulse
   always_comb begin
      nextState = state;
      case (state)
         WAIT_FRAME: if (bus.startOfFrame) nextState = ACCUM;
         ACCUM:      if (bus.startOfFrame) nextState = REPORT;
         REPORT:     nextState = bus.startOfFrame ? REPORT : ACCUM;
         default:    nextState = WAIT_FRAME;
      endcase
   end

   // The startOfFrame pixel seeds the new frame; the REPORT cycle keeps accumulating
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt  <= '0;
         minX <= COORD_W'(SCREEN_W - 1);
         maxX <= '0;
      end else if (bus.startOfFrame) begin
         cnt  <= {{(CNT_WIDTH-1){1'b0}}, overlap};
         minX <= overlap ? x : COORD_W'(SCREEN_W - 1);
         maxX <= overlap ? x : '0;
      end else if (state != WAIT_FRAME && overlap) begin
         if (cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
         if (x < minX) minX <= x;
         if (x > maxX) maxX <= x;
      end
   end

   // Results are captured as the frame closes so they are valid while frameDone is high
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frameDoneR    <= 1'b0;
         overlapCountR <= '0;
         ropeSnapXR    <= '0;
      end else begin
         frameDoneR <= closeFrame;
         if (closeFrame) begin
            overlapCountR <= cnt;
            if (cnt != '0) ropeSnapXR <= snapSum[COORD_W:1];
         end
      end
   end

   assign frameContact = overlapCountR >= CNT_WIDTH'(MIN_OVERLAP_PIXELS);

   frame_debouncer #(
      .GRAB_FRAMES    (GRAB_FRAMES),
      .RELEASE_FRAMES (RELEASE_FRAMES)
   ) u_debouncer (
      .clk          (clk),
      .resetN       (resetN),
      .frameStrobe  (frameDoneR),
      .frameContact (frameContact),
      .onRope       (bus.onRope),
      .grabPulse    (bus.grabPulse),
      .releasePulse (bus.releasePulse)
   );

   assign bus.frameDone    = frameDoneR;
   assign bus.overlapCount = overlapCountR;
   assign bus.ropeSnapX    = ropeSnapXR;
   assign stateDbg         = state;

endmodule

// File: doc/rope_contact_detector.md
Name: rope_contact_detector

Overview:
- Sits directly downstream of the rope display stage. Consumes the per-pixel rope drawing request and the player sprite drawing request during the VGA raster scan.
- Accumulates their overlap over each frame and decides once per frame whether the player is holding a rope.
- Publishes frame-stable results to game control: contact flag, overlap statistics, grab/release pulses, and a rope snap X coordinate.

Parameters:
- MIN_OVERLAP_PIXELS, 16, minimum overlapping pixels in one frame for that frame to count as contact
- GRAB_FRAMES, 2, consecutive contact frames required before onRope asserts
- RELEASE_FRAMES, 3, consecutive non-contact frames required before onRope deasserts
- CNT_WIDTH, 12, width of the overlap pixel counter (saturating)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse marking the first pixel of a frame
- pixelX  in  11  current VGA pixel X
- pixelY  in  11  current VGA pixel Y
- ropeDR  in  1  rope drawing request for the current pixel
- playerDR  in  1  player sprite drawing request for the current pixel
- onRope  out  1  debounced "player holding rope" flag
- grabPulse  out  1  one-cycle pulse when onRope rises
- releasePulse  out  1  one-cycle pulse when onRope falls
- frameDone  out  1  one-cycle pulse when the frame results below update
- overlapCount  out  CNT_WIDTH  overlap pixels in the last completed frame
- ropeSnapX  out  11  (minX+maxX)/2 of the overlap in the last completed frame

Behaviour:
- Reset (asynchronous, resetN=0): all outputs 0; counters and streak counters 0; minX=2047, maxX=0; state WAIT_FRAME.
- Overlap pixel: ropeDR && playerDR, sampled on the clk edge.
- State machine:
  - WAIT_FRAME: ignore all pixels. startOfFrame moves to ACCUM and clears the accumulators, counting the current pixel as the first pixel of the new frame.
  - ACCUM: on each overlap pixel, increment the counter (saturates at all-ones, no wrap) and update minX/maxX. startOfFrame moves to REPORT for exactly one cycle. The pixel present in that startOfFrame cycle belongs to the new frame: it seeds fresh accumulators and is not folded into the old frame.
  - REPORT: latch the finished frame into overlapCount and ropeSnapX; assert frameDone for this one cycle; update the debounce logic; return to ACCUM.
- Overlap pixels arriving in the REPORT cycle are accumulated into the new frame; the REPORT cycle loses no pixels.
- ropeSnapX: computed with a 12-bit sum, shifted right by 1. If the frame had zero overlap, ropeSnapX holds its previous value.
- Frame contact: overlapCount >= MIN_OVERLAP_PIXELS.
- Debounce:
  - Contact frames increment contactStreak and clear missStreak; non-contact frames do the opposite. Both streaks saturate.
  - onRope rises when contactStreak reaches GRAB_FRAMES and falls when missStreak reaches RELEASE_FRAMES.
- Output timing:
  - onRope changes on the cycle after REPORT.
  - grabPulse/releasePulse assert on that same cycle, for one cycle.
  - frameDone leads onRope by one cycle.
- Latency: pixel overlap to frameDone = end of its frame + 1 cycle; to onRope = end of frame + 2 cycles.
- startOfFrame pulses on consecutive cycles: each pulse closes a frame; a zero-overlap frame counts as a miss.
- Reset mid-frame: all state is discarded and the block waits for the next startOfFrame; no pulses are produced.

Decomposition:
- Shared package (game_pkg):
  - state enum {WAIT_FRAME, ACCUM, REPORT}
  - VGA coordinate width constant (11)
  - screen width constant used for the minX reset value
- One sub-module: frame_debouncer. Takes the per-frame contact bit and frame strobe; produces onRope, grabPulse, releasePulse; parameterised by GRAB_FRAMES and RELEASE_FRAMES.
- The top level holds the accumulator and the state machine.

Test Plan:
- Reset then steady overlap: 20 overlap pixels at X=150..169 per frame for 2 frames → overlapCount=20 and ropeSnapX=159 at each frameDone; grabPulse on the 2nd frame; onRope=1 and stays 1.
- Below threshold: 15 overlap pixels per frame for 5 frames → onRope stays 0, no pulses, overlapCount=15.
- Release: onRope=1, then 3 frames with 0 overlap → releasePulse and onRope=0 after the 3rd frame; ropeSnapX unchanged from the last contact frame.
- Glitch rejection: contact/miss/contact/miss pattern with GRAB_FRAMES=2 → onRope never asserts.
- Boundary: overlap on the startOfFrame cycle and on the REPORT cycle → both counted in the new frame; previous overlapCount excludes them; saturation test with 5000 overlap pixels and CNT_WIDTH=12 → overlapCount=4095.
- resetN pulled low mid-ACCUM with 10 overlap pixels accumulated → outputs 0 immediately; no frameDone until one full frame after the next startOfFrame.
